uart_tx: RTL and testbench

- 8N1 UART transmitter; the serial back end for the memory-mapped IO block's UART transmit path.
- Consumes the IO block's transmit-data byte and transmit level bit, and drives the txd pin.
- Returns a sticky done flag that software polls through the UART control register.
- The same ports serve the boot loader when the IO block muxes in the boot source.

---
 rtl/uart_tx.sv | 130 +++++++++++++
 tb/tb_uart_tx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx : 8N1 UART transmitter (serial back end of the IO block's TX path)
//
// Ports
//   clk       in   system clock, all state on the rising edge
//   rst_n     in   asynchronous reset, active-low
//   tx_data   in   [7:0] byte to send, sampled only on the start-accept cycle
//   transmit  in   level request; a frame starts on its rising edge
//   txd       out  serial line, registered, idle high
//   txd_done  out  sticky completion flag, cleared when the next frame starts
//   busy      out  high while a frame is in progress (state != IDLE)
//
// Frame: start bit (0), 8 data bits LSB first, one stop bit (1); each bit lasts
// CLKS_PER_BIT clocks, so a frame is 10*CLKS_PER_BIT clocks from the accept edge.
// -----------------------------------------------------------------------------
module uart_tx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       transmit,
   output logic       txd,
   output logic       txd_done,
   output logic       busy
);

   localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] baud_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;
   logic             transmit_q;
   logic             txd_q;
   logic             done_q;

   logic             start_req;
   logic             baud_last;

   // Only a fresh rising edge of the level request starts a frame, so a request
   // left high after completion never retriggers. transmit_q resets low, which
   // lets a request held through reset release start a frame immediately.
   assign start_req = transmit & ~transmit_q;
   assign baud_last = (baud_q == BAUD_LAST);

   assign busy     = (state_q != IDLE);
   assign txd      = txd_q;
   assign txd_done = done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         transmit_q <= 1'b0;
         txd_q      <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         transmit_q <= transmit;

         case (state_q)
            IDLE: begin
               txd_q <= 1'b1;
               // Rising edges seen in any other state are simply dropped.
               if (start_req) begin
                  shift_q <= tx_data;
                  txd_q   <= 1'b0;
                  done_q  <= 1'b0;
                  baud_q  <= '0;
                  state_q <= START;
               end
            end

            START: begin
               if (baud_last) begin
                  baud_q    <= '0;
                  txd_q     <= shift_q[0];
                  bit_idx_q <= '0;
                  state_q   <= DATA;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end

            DATA: begin
               if (baud_last) begin
                  baud_q <= '0;
                  if (bit_idx_q != 3'd7) begin
                     // shift_q[1] is the bit that becomes shift_q[0] after the shift.
                     shift_q   <= {1'b0, shift_q[7:1]};
                     txd_q     <= shift_q[1];
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end else begin
                     txd_q   <= 1'b1;
                     state_q <= STOP;
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end

            STOP: begin
               if (baud_last) begin
                  baud_q  <= '0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end

            default: begin
               txd_q   <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx : directed, table-driven bench for uart_tx with CLKS_PER_BIT = 4.
// Edge 0 is the clock edge on which the rising transmit request is sampled;
// outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_uart_tx;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       transmit;
   logic       txd;
   logic       txd_done;
   logic       busy;

   int checks;
   int errors;

   uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_data  (tx_data),
      .transmit (transmit),
      .txd      (txd),
      .txd_done (txd_done),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected serial frame: bit i is the line level during bit period i
   // (bit 0 = start, bits 1..8 = data LSB first, bit 9 = stop).
   typedef struct {
      logic [7:0] data;
      logic [9:0] exp;
      bit         alt_en;
      logic [7:0] alt;
      bit         glitch;
   } vec_t;

   vec_t vecs [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs edges 0..FRAME-1 of a frame whose request is already driven high.
   task automatic frame_body(input string tag, input logic [9:0] exp,
                             input bit alt_en, input logic [7:0] alt,
                             input bit glitch, input bit drop38);
      for (int c = 0; c < FRAME; c++) begin
         tick();
         chk($sformatf("%s_txd_e%0d", tag, c), {31'd0, txd}, {31'd0, exp[c / CPB]});
         chk($sformatf("%s_busy_e%0d", tag, c), {31'd0, busy}, 32'd1);
         chk($sformatf("%s_done_e%0d", tag, c), {31'd0, txd_done}, 32'd0);
         if (alt_en && c == 1) tx_data = alt;
         if (glitch && c == 11) transmit = 1'b0;
         if (glitch && c == 12) transmit = 1'b1;
         if (drop38 && c == 38) transmit = 1'b0;
      end
   endtask

   task automatic idle_chk(input string tag, input logic exp_done);
      chk({tag, "_txd"},  {31'd0, txd},      32'd1);
      chk({tag, "_busy"}, {31'd0, busy},     32'd0);
      chk({tag, "_done"}, {31'd0, txd_done}, {31'd0, exp_done});
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      transmit = 1'b0;
      tx_data  = 8'h00;

      vecs[0] = '{data: 8'hA5, exp: 10'b1101001010, alt_en: 0, alt: 8'h00, glitch: 0};
      vecs[1] = '{data: 8'h00, exp: 10'b1000000000, alt_en: 0, alt: 8'h00, glitch: 1};
      vecs[2] = '{data: 8'h3C, exp: 10'b1001111000, alt_en: 1, alt: 8'hFF, glitch: 0};
      vecs[3] = '{data: 8'hFF, exp: 10'b1111111110, alt_en: 0, alt: 8'h00, glitch: 0};

      // Reset state, then a quiet idle period.
      #12;
      idle_chk("reset", 1'b0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         idle_chk($sformatf("idle%0d", i), 1'b0);
      end

      // Table-driven frames; request held high afterwards must not retrigger.
      for (int v = 0; v < 4; v++) begin
         tx_data  = vecs[v].data;
         transmit = 1'b1;
         frame_body($sformatf("v%0d", v), vecs[v].exp, vecs[v].alt_en,
                    vecs[v].alt, vecs[v].glitch, 1'b0);
         tick();
         idle_chk($sformatf("v%0d_end", v), 1'b1);
         for (int h = 0; h < 8; h++) begin
            tick();
            idle_chk($sformatf("v%0d_hold%0d", v, h), 1'b1);
         end
         transmit = 1'b0;
         tick();
         tick();
      end

      // Back-to-back: 0x55, request dropped after edge 38, raised again as soon
      // as IDLE is entered (edge 40) so the second frame is accepted on edge 41.
      tx_data  = 8'h55;
      transmit = 1'b1;
      frame_body("b2b_a", 10'b1010101010, 1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      idle_chk("b2b_gap", 1'b1);
      tx_data  = 8'h81;
      transmit = 1'b1;
      frame_body("b2b_b", 10'b1100000010, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      idle_chk("b2b_end", 1'b1);
      transmit = 1'b0;
      tick();

      // Reset mid-frame: line returns high without waiting for a clock edge.
      tx_data  = 8'h00;
      transmit = 1'b1;
      for (int c = 0; c <= 17; c++) tick();
      chk("mid_busy_before", {31'd0, busy}, 32'd1);
      chk("mid_txd_before", {31'd0, txd}, 32'd0);
      rst_n = 1'b0;
      #1;
      idle_chk("mid_async", 1'b0);
      transmit = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      idle_chk("mid_after", 1'b0);
      tx_data  = 8'hA5;
      transmit = 1'b1;
      frame_body("post_rst", 10'b1101001010, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      idle_chk("post_rst_end", 1'b1);
      transmit = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
